// File: rtl/vga_pkg.sv
// Shared raster-timing definitions: phase encoding, default 640x480@60
// timing and the counter-to-phase decode used on both axes.
package vga_pkg;

  // Position of a counter within one axis of the raster.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

  // Current phase of both axes, decoded from the live counters.
  typedef struct packed {
    phase_t h;
    phase_t v;
  } phase_pair_t;

  // Default 640x480@60 timing (25.175 MHz nominal pixel rate).
  localparam int unsigned H_DISP_DEF  = 640;
  localparam int unsigned H_FP_DEF    = 16;
  localparam int unsigned H_PULSE_DEF = 96;
  localparam int unsigned H_BP_DEF    = 48;
  localparam int unsigned V_DISP_DEF  = 480;
  localparam int unsigned V_FP_DEF    = 10;
  localparam int unsigned V_PULSE_DEF = 2;
  localparam int unsigned V_BP_DEF    = 33;

  // Bands are checked in raster order, so a zero-width porch never matches.
  function automatic phase_t phase_of(input int unsigned cnt,
                                      input int unsigned disp,
                                      input int unsigned fp,
                                      input int unsigned pulse);
    phase_t ph;
    if (cnt < disp)                   ph = ACTIVE;
    else if (cnt < disp + fp)         ph = FP;
    else if (cnt < disp + fp + pulse) ph = SYNC;
    else                              ph = BP;
    return ph;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a modulo-(limit+1) up-counter with a wrap pulse that is
// high on the enabled cycle where the count rolls back to zero.
module vga_axis_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == limit);

  // Advance on enable, rolling over from limit back to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters advanced by the
// pixel-clock enable, decoded into sync, blank, coordinates and strobes.
// Every output is registered one clk after the counter value it reflects.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = H_DISP_DEF,
  parameter int unsigned HFP    = H_FP_DEF,
  parameter int unsigned HPULSE = H_PULSE_DEF,
  parameter int unsigned HBP    = H_BP_DEF,
  parameter int unsigned VDISP  = V_DISP_DEF,
  parameter int unsigned VFP    = V_FP_DEF,
  parameter int unsigned VPULSE = V_PULSE_DEF,
  parameter int unsigned VBP    = V_BP_DEF,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int unsigned HCNT_W = (HTOTAL > 1) ? $clog2(HTOTAL) : 1,
  localparam int unsigned VCNT_W = (VTOTAL > 1) ? $clog2(VTOTAL) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              pix_en,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank,
  output logic [HCNT_W-1:0] pix_x,
  output logic [VCNT_W-1:0] pix_y,
  output logic              line_start,
  output logic              frame_start
);

  // A zero-width sync pulse would leave the monitor with no sync at all.
  if (HPULSE < 1) begin : g_hpulse_check
    $error("vga_timing_gen: HPULSE must be at least 1");
  end
  if (VPULSE < 1) begin : g_vpulse_check
    $error("vga_timing_gen: VPULSE must be at least 1");
  end

  localparam logic [HCNT_W-1:0] H_LIMIT = HCNT_W'(HTOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LIMIT = VCNT_W'(VTOTAL - 1);

  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              h_wrap;
  logic              v_wrap_unused;
  phase_pair_t       phase_now;

  vga_axis_counter #(.W(HCNT_W)) u_hcnt (
    .clk   (clk),
    .nrst  (nrst),
    .en    (pix_en),
    .limit (H_LIMIT),
    .count (hcnt),
    .wrap  (h_wrap)
  );

  // The line counter steps once per horizontal wrap.
  vga_axis_counter #(.W(VCNT_W)) u_vcnt (
    .clk   (clk),
    .nrst  (nrst),
    .en    (h_wrap),
    .limit (V_LIMIT),
    .count (vcnt),
    .wrap  (v_wrap_unused)
  );

  // Decode both live counters into their timing phase.
  always_comb begin
    phase_now   = '{h: ACTIVE, v: ACTIVE};
    phase_now.h = phase_of(32'(hcnt), HDISP, HFP, HPULSE);
    phase_now.v = phase_of(32'(vcnt), VDISP, VFP, VPULSE);
  end

  // Register the decoded position; outputs hold while disabled, strobes drop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vga_hs      <= !HS_POL;
      vga_vs      <= !VS_POL;
      vga_blank   <= 1'b1;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      vga_hs      <= (phase_now.h == SYNC) ? HS_POL : !HS_POL;
      vga_vs      <= (phase_now.v == SYNC) ? VS_POL : !VS_POL;
      vga_blank   <= !((phase_now.h == ACTIVE) && (phase_now.v == ACTIVE));
      pix_x       <= hcnt;
      pix_y       <= vcnt;
      line_start  <= (hcnt == '0);
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
